vga_frame_grabber: RTL

Parametrised VGA pixel capture peripheral on the HPS Avalon-MM lightweight bus. It taps the VGA output stream (RGB plus syncs), waits for a frame boundary, and pushes active pixels into an on-chip FIFO. Software drains the FIFO by register reads and polls status, line and pixel counters. A decimation mode can be compiled in.

---
 rtl/vga_grab_pkg.sv | 32 +++
 rtl/grab_fifo.sv | 61 ++++++
 rtl/vga_frame_grabber.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vga_grab_pkg.sv
// Shared types and register map for the VGA frame grabber.
package vga_grab_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } grab_state_t;

  localparam logic [7:0] REG_DATA    = 8'd0;
  localparam logic [7:0] REG_STATUS  = 8'd1;
  localparam logic [7:0] REG_PIXCNT  = 8'd2;
  localparam logic [7:0] REG_LINECNT = 8'd3;

  localparam int unsigned CTRL_ARM   = 0;
  localparam int unsigned CTRL_ABORT = 1;
  localparam int unsigned CTRL_CONT  = 2;
  localparam int unsigned CTRL_DECIM = 3;

  localparam int unsigned STAT_STATE_LSB  = 0;
  localparam int unsigned STAT_OVERFLOW   = 2;
  localparam int unsigned STAT_UNDERFLOW  = 3;
  localparam int unsigned STAT_FRAME_DONE = 4;
  localparam int unsigned STAT_LEVEL_LSB  = 8;

  // FIFO level as reported in STATUS, clamped to the 8-bit field.
  function automatic logic [7:0] sat_level(input logic [31:0] lvl);
    return (lvl > 32'd255) ? 8'hff : lvl[7:0];
  endfunction

endpackage

// File: rtl/grab_fifo.sv
// Single-clock FIFO with flush and level output; reading while empty returns 0.
module grab_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        level_q <= level_q + LW'(1);
      end else if (pop_ok && !push_ok) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_frame_grabber.sv
// Avalon-MM VGA pixel capture peripheral: taps the VGA stream into a FIFO drained by reads.
// Optional even-pixel/even-line decimation is compiled in with VGA_GRAB_DECIM_EN.
module vga_frame_grabber
  import vga_grab_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       address,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [PIX_W-1:0] VGA_R,
  input  logic [PIX_W-1:0] VGA_G,
  input  logic [PIX_W-1:0] VGA_B,
  input  logic             VGA_BLANK_n,
  input  logic             pix_ce,
  input  logic             HSYNC,
  input  logic             VSYNC,
  output logic             get_img
);

  localparam int unsigned CW = 3 * PIX_W;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  grab_state_t      state_q, state_d;
  logic             vsync_q, hsync_q;
  logic             cont_q, cont_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]      line_cnt_q, line_cnt_d;

  logic             vsync_fall, hsync_fall;
  logic             ctrl_wr, data_rd, abort, arm;
  logic             in_capture, frame_edge, active, decim_ok, capture;

  logic [CW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;

  assign vsync_fall = vsync_q & ~VSYNC;
  assign hsync_fall = hsync_q & ~HSYNC;

  assign ctrl_wr = chipselect & write & (address == REG_DATA);
  assign data_rd = chipselect & read & (address == REG_DATA);
  assign abort   = ctrl_wr & writedata[CTRL_ABORT];
  // ARM is honoured only from IDLE or DONE, and ABORT wins when both are set.
  assign arm     = ctrl_wr & writedata[CTRL_ARM] & ~writedata[CTRL_ABORT] &
                   ((state_q == StIdle) | (state_q == StDone));

  assign in_capture = (state_q == StCapture);
  assign frame_edge = in_capture & vsync_fall;
  assign active     = pix_ce & VGA_BLANK_n;
  assign capture    = in_capture & active & decim_ok;
  assign get_img    = in_capture;

`ifdef VGA_GRAB_DECIM_EN
  logic decim_q, decim_d;
  logic parity_q, parity_d;

  assign decim_ok = ~decim_q | (~parity_q & ~line_cnt_q[0]);
  assign decim_d  = arm ? writedata[CTRL_DECIM] : decim_q;

  always_comb begin
    parity_d = parity_q;
    if (hsync_fall || vsync_fall || arm) begin
      parity_d = 1'b0;
    end else if (active) begin
      parity_d = ~parity_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      decim_q  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      decim_q  <= decim_d;
      parity_q <= parity_d;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:CTRL_DECIM+1];
`else
  assign decim_ok = 1'b1;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:CTRL_DECIM];
`endif

  grab_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort | arm),
    .push  (capture),
    .pop   (data_rd),
    .wdata ({VGA_R, VGA_G, VGA_B}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (arm) state_d = StArmed;
        StArmed:   if (vsync_fall) state_d = StCapture;
        StCapture: if (vsync_fall && !cont_q) state_d = StDone;
        StDone:    if (arm) state_d = StArmed;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cont_d       = arm ? writedata[CTRL_CONT] : cont_q;
    // A dropped pixel is one pushed while full with no pop freeing a slot.
    overflow_d   = overflow_q | (capture & fifo_full & ~data_rd);
    underflow_d  = underflow_q | (data_rd & fifo_empty);
    frame_done_d = frame_done_q | frame_edge;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    if (capture) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end
    if (in_capture && hsync_fall) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end
    if (frame_edge && cont_q) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end
    if (arm) begin
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      frame_done_d = 1'b0;
      pix_cnt_d    = '0;
      line_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      cont_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= VSYNC;
      hsync_q      <= HSYNC;
      cont_q       <= cont_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA: readdata[31 -: CW] = fifo_rdata;
      REG_STATUS: begin
        readdata[STAT_STATE_LSB +: 2]  = state_q;
        readdata[STAT_OVERFLOW]        = overflow_q;
        readdata[STAT_UNDERFLOW]       = underflow_q;
        readdata[STAT_FRAME_DONE]      = frame_done_q;
        readdata[STAT_LEVEL_LSB +: 8]  = sat_level(32'(fifo_level));
      end
      REG_PIXCNT:  readdata = 32'(pix_cnt_q);
      REG_LINECNT: readdata = 32'(line_cnt_q);
      default:     readdata = '0;
    endcase
  end

endmodule
